// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: stage register/source info in, stage enables,
// flushes, forward selects and status out.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  ex_rs1_i;
  logic [4:0]  ex_rs2_i;
  logic [4:0]  ex_rd_i;
  logic        ex_regwen_i;
  logic        ex_is_load_i;
  logic [4:0]  mem_rd_i;
  logic        mem_regwen_i;
  logic [4:0]  wb_rd_i;
  logic        wb_regwen_i;
  logic        br_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic [1:0]  asel_haz_o;
  logic [1:0]  bsel_haz_o;
  logic        en_pc_o;
  logic        en_id_o;
  logic        en_ex_o;
  logic        en_mem_o;
  logic        en_wb_o;
  logic        flush_id_o;
  logic        flush_ex_o;
  logic        pc_redirect_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i,
    output ex_rd_i, ex_regwen_i, ex_is_load_i,
    output mem_rd_i, mem_regwen_i, wb_rd_i, wb_regwen_i,
    output br_taken_i, mem_req_i, mem_ack_i,
    input  asel_haz_o, bsel_haz_o,
    input  en_pc_o, en_id_o, en_ex_o, en_mem_o, en_wb_o,
    input  flush_id_o, flush_ex_o, pc_redirect_o,
    input  err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i,
    input  ex_rd_i, ex_regwen_i, ex_is_load_i,
    input  mem_rd_i, mem_regwen_i, wb_rd_i, wb_regwen_i,
    input  br_taken_i, mem_req_i, mem_ack_i,
    output asel_haz_o, bsel_haz_o,
    output en_pc_o, en_id_o, en_ex_o, en_mem_o, en_wb_o,
    output flush_id_o, flush_ex_o, pc_redirect_o,
    output err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: forwarding, load-use bubble, branch flush, MEM stall
// with watchdog. Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic              clk_i,
  input logic              rst_ni,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_e;

  state_e        st_q, st_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic en_pc, en_id, en_ex, en_mem, en_wb;
  logic flush_id, flush_ex, redir, go;
  logic load_use;
  logic [1:0] asel, bsel;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       m_wen,
    input logic [4:0] m_rd,
    input logic       w_wen,
    input logic [4:0] w_rd
  );
    logic [1:0] s;
    s = 2'd0;
    if (m_wen && m_rd != 5'd0 && m_rd == rs)
      s = 2'd1;
    else if (w_wen && w_rd != 5'd0 && w_rd == rs)
      s = 2'd2;
    return s;
  endfunction

  always_comb begin
    asel = fwd_sel(hz.ex_rs1_i, hz.mem_regwen_i,
                   hz.mem_rd_i, hz.wb_regwen_i, hz.wb_rd_i);
    bsel = fwd_sel(hz.ex_rs2_i, hz.mem_regwen_i,
                   hz.mem_rd_i, hz.wb_regwen_i, hz.wb_rd_i);
  end

  assign load_use = hz.ex_is_load_i & hz.ex_regwen_i &
                    (hz.ex_rd_i != 5'd0) &
                    ((hz.ex_rd_i == hz.id_rs1_i) |
                     (hz.ex_rd_i == hz.id_rs2_i));

  always_comb begin
    st_d   = st_q;
    wdog_d = wdog_q;
    go     = 1'b0;
    unique case (st_q)
      RUN: begin
        if (hz.mem_req_i && !hz.mem_ack_i) begin
          st_d   = MEM_WAIT;
          wdog_d = WW'(1);
        end else begin
          go = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ack_i) begin
          go   = 1'b1;
          st_d = RUN;
        end else begin
          if (wdog_q != '1)
            wdog_d = wdog_q + WW'(1);
          if (MEM_TIMEOUT != 0 && wdog_q == WW'(MEM_TIMEOUT))
            st_d = ERR;
        end
      end
      ERR: st_d = ERR;
      default: st_d = RUN;
    endcase
  end

  // A held branch only redirects once the stall releases (go=1).
  always_comb begin
    en_pc    = 1'b0;
    en_id    = 1'b0;
    en_ex    = 1'b0;
    en_mem   = 1'b0;
    en_wb    = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    redir    = 1'b0;
    if (go) begin
      en_mem = 1'b1;
      en_wb  = 1'b1;
      unique case (1'b1)
        hz.br_taken_i: begin
          en_pc    = 1'b1;
          en_id    = 1'b1;
          en_ex    = 1'b1;
          redir    = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end
        (!hz.br_taken_i && load_use): begin
          en_ex    = 1'b1;
          flush_ex = 1'b1;
        end
        (!hz.br_taken_i && !load_use): begin
          en_pc = 1'b1;
          en_id = 1'b1;
          en_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= RUN;
      wdog_q <= '0;
    end else begin
      st_q   <= st_d;
      wdog_q <= wdog_d;
    end
  end

  assign hz.asel_haz_o    = rst_ni ? asel : 2'd0;
  assign hz.bsel_haz_o    = rst_ni ? bsel : 2'd0;
  assign hz.en_pc_o       = rst_ni & en_pc;
  assign hz.en_id_o       = rst_ni & en_id;
  assign hz.en_ex_o       = rst_ni & en_ex;
  assign hz.en_mem_o      = rst_ni & en_mem;
  assign hz.en_wb_o       = rst_ni & en_wb;
  assign hz.flush_id_o    = rst_ni & flush_id;
  assign hz.flush_ex_o    = rst_ni & flush_ex;
  assign hz.pc_redirect_o = rst_ni & redir;
  assign hz.err_o         = rst_ni & (st_q == ERR);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en_mem && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (redir && flush_q != '1)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cnt_o = rst_ni ? stall_q : 32'h0;
  assign hz.flush_cnt_o = rst_ni ? flush_q : 32'h0;
`else
  assign hz.stall_cnt_o = 32'h0;
  assign hz.flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks plus a randomized
// run compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .hz    (hz)
  );

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int fsel(int rs, bit mw, int mrd, bit ww, int wrd);
    if (mw && mrd != 0 && mrd == rs) return 1;
    if (ww && wrd != 0 && wrd == rs) return 2;
    return 0;
  endfunction

  // model: sticky error, waiting flag, cycles spent stalled so far
  bit     m_err = 0;
  bit     m_wait = 0;
  int     m_cnt = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  always @(negedge clk) begin : cmp
    int  ea, eb;
    bit  pc, id, ex, mm, wb, fi, fe, rd, frozen, lu;
    ea = 0; eb = 0;
    pc = 0; id = 0; ex = 0; mm = 0; wb = 0; fi = 0; fe = 0; rd = 0;
    if (rst_n) begin
      ea = fsel(int'(hz.ex_rs1_i), hz.mem_regwen_i, int'(hz.mem_rd_i),
                hz.wb_regwen_i, int'(hz.wb_rd_i));
      eb = fsel(int'(hz.ex_rs2_i), hz.mem_regwen_i, int'(hz.mem_rd_i),
                hz.wb_regwen_i, int'(hz.wb_rd_i));
      lu = hz.ex_is_load_i && hz.ex_regwen_i && hz.ex_rd_i != 0 &&
           (hz.ex_rd_i == hz.id_rs1_i || hz.ex_rd_i == hz.id_rs2_i);
      frozen = m_err || (m_wait ? !hz.mem_ack_i
                                : (hz.mem_req_i && !hz.mem_ack_i));
      if (!frozen) begin
        mm = 1; wb = 1;
        if (hz.br_taken_i) begin
          pc = 1; id = 1; ex = 1; rd = 1; fi = 1; fe = 1;
        end else if (lu) begin
          ex = 1; fe = 1;
        end else begin
          pc = 1; id = 1; ex = 1;
        end
      end
    end
    chk("asel", hz.asel_haz_o, ea);
    chk("bsel", hz.bsel_haz_o, eb);
    chk("en_pc", hz.en_pc_o, pc);
    chk("en_id", hz.en_id_o, id);
    chk("en_ex", hz.en_ex_o, ex);
    chk("en_mem", hz.en_mem_o, mm);
    chk("en_wb", hz.en_wb_o, wb);
    chk("flush_id", hz.flush_id_o, fi);
    chk("flush_ex", hz.flush_ex_o, fe);
    chk("redirect", hz.pc_redirect_o, rd);
    chk("err", hz.err_o, rst_n && m_err);
    chk("stall_cnt", hz.stall_cnt_o, (PERF && rst_n) ? m_stall : 0);
    chk("flush_cnt", hz.flush_cnt_o, (PERF && rst_n) ? m_flush : 0);
    if (!rst_n) begin
      m_err = 0; m_wait = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!mm) m_stall++;
      if (rd) m_flush++;
      if (m_err) begin
      end else if (!m_wait) begin
        if (hz.mem_req_i && !hz.mem_ack_i) begin
          m_wait = 1; m_cnt = 1;
        end
      end else if (hz.mem_ack_i) begin
        m_wait = 0;
      end else if (m_cnt == TMO) begin
        m_err = 1; m_wait = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic idle();
    hz.id_rs1_i = 0; hz.id_rs2_i = 0;
    hz.ex_rs1_i = 0; hz.ex_rs2_i = 0;
    hz.ex_rd_i = 0; hz.ex_regwen_i = 0; hz.ex_is_load_i = 0;
    hz.mem_rd_i = 0; hz.mem_regwen_i = 0;
    hz.wb_rd_i = 0; hz.wb_regwen_i = 0;
    hz.br_taken_i = 0; hz.mem_req_i = 0; hz.mem_ack_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    hz.ex_rs1_i = 5; hz.mem_rd_i = 5; hz.mem_regwen_i = 1;
    hz.wb_rd_i = 5; hz.wb_regwen_i = 1;
    tick();
    #1;
    chk("rst_asel", hz.asel_haz_o, 0);
    chk("rst_en_pc", hz.en_pc_o, 0);
    chk("rst_err", hz.err_o, 0);
    // forwarding priority
    tick(); rst_n = 1; #1;
    chk("fwd_mem", hz.asel_haz_o, 1);
    tick(); hz.mem_regwen_i = 0; #1;
    chk("fwd_wb", hz.asel_haz_o, 2);
    tick(); hz.wb_rd_i = 0; hz.mem_rd_i = 0; hz.mem_regwen_i = 1; #1;
    chk("fwd_x0", hz.asel_haz_o, 0);
    tick(); hz.ex_rs2_i = 9; hz.wb_rd_i = 9; #1;
    chk("fwd_b", hz.bsel_haz_o, 2);
    // load-use bubble
    tick(); idle();
    hz.ex_is_load_i = 1; hz.ex_regwen_i = 1; hz.ex_rd_i = 7; hz.id_rs2_i = 7;
    #1;
    chk("lu_en_pc", hz.en_pc_o, 0);
    chk("lu_en_id", hz.en_id_o, 0);
    chk("lu_en_ex", hz.en_ex_o, 1);
    chk("lu_flush_ex", hz.flush_ex_o, 1);
    tick(); idle(); #1;
    chk("lu_after", hz.en_pc_o, 1);
    chk("lu_after_fl", hz.flush_ex_o, 0);
    // taken branch
    tick(); hz.br_taken_i = 1; #1;
    chk("br_redir", hz.pc_redirect_o, 1);
    chk("br_flush_id", hz.flush_id_o, 1);
    chk("br_en_pc", hz.en_pc_o, 1);
    tick(); hz.br_taken_i = 0; #1;
    chk("br_fcnt", hz.flush_cnt_o, PERF ? 1 : 0);
    chk("br_scnt", hz.stall_cnt_o, 0);
    // three stall cycles, branch held until release
    tick(); hz.mem_req_i = 1; #1;
    chk("mw_c1", hz.en_mem_o, 0);
    tick(); hz.br_taken_i = 1; #1;
    chk("mw_c2", hz.en_pc_o, 0);
    chk("mw_held", hz.pc_redirect_o, 0);
    tick(); #1;
    chk("mw_c3", hz.en_ex_o, 0);
    tick(); hz.mem_ack_i = 1; #1;
    chk("mw_rel_pc", hz.en_pc_o, 1);
    chk("mw_rel_mem", hz.en_mem_o, 1);
    chk("mw_rel_redir", hz.pc_redirect_o, 1);
    tick(); idle(); #1;
    chk("mw_run", hz.en_pc_o, 1);
    chk("mw_scnt", hz.stall_cnt_o, PERF ? 3 : 0);
    chk("mw_fcnt", hz.flush_cnt_o, PERF ? 2 : 0);
    // watchdog
    tick(); hz.mem_req_i = 1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("wd_stall", hz.en_mem_o, 0);
      chk("wd_noerr", hz.err_o, 0);
      tick();
    end
    chk("wd_err", hz.err_o, 1);
    hz.mem_ack_i = 1; #1;
    chk("wd_ackign", hz.en_pc_o, 0);
    tick();
    chk("wd_sticky", hz.err_o, 1);
    // reset in the middle of a stall
    rst_n = 0;
    tick(); rst_n = 1; idle(); hz.mem_req_i = 1;
    tick(); tick();
    rst_n = 0; hz.ex_rs1_i = 3; hz.mem_rd_i = 3; hz.mem_regwen_i = 1;
    #1;
    chk("mrst_en", hz.en_mem_o, 0);
    chk("mrst_asel", hz.asel_haz_o, 0);
    tick(); rst_n = 1; idle(); #1;
    chk("mrst_err", hz.err_o, 0);
    chk("mrst_run", hz.en_pc_o, 1);
    // randomized
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 39) != 0);
      hz.id_rs1_i = 5'($urandom_range(0, 3));
      hz.id_rs2_i = 5'($urandom_range(0, 3));
      hz.ex_rs1_i = 5'($urandom_range(0, 3));
      hz.ex_rs2_i = 5'($urandom_range(0, 3));
      hz.ex_rd_i = 5'($urandom_range(0, 3));
      hz.mem_rd_i = 5'($urandom_range(0, 3));
      hz.wb_rd_i = 5'($urandom_range(0, 3));
      hz.ex_regwen_i = 1'($urandom_range(0, 1));
      hz.ex_is_load_i = 1'($urandom_range(0, 1));
      hz.mem_regwen_i = 1'($urandom_range(0, 1));
      hz.wb_regwen_i = 1'($urandom_range(0, 1));
      hz.br_taken_i = ($urandom_range(0, 4) == 0);
      hz.mem_req_i = ($urandom_range(0, 2) == 0);
      hz.mem_ack_i = ($urandom_range(0, 2) != 0);
    end
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
